dram_cmd_arbiter: RTL and testbench

Round-robin arbiter that shares one DRAM command FIFO write port between NUM_REQ requesters (e.g. refresh engine, read port, write port).
- Grants one requester at a time and passes its beats through to the FIFO write side combinationally.
- Holds a grant for one burst: until a beat tagged last, or MAX_BURST beats.
- Sits directly in front of the command FIFO and honours its full flag.

---
 rtl/dram_cmd_arbiter.sv | 122 ++++++++++++
 tb/tb_dram_cmd_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_cmd_arbiter.sv
// dram_cmd_arbiter: round-robin arbiter sharing one DRAM command FIFO write
// port between NUM_REQ requesters. A grant lasts one burst, which ends on a
// beat tagged last or after MAX_BURST beats. Beats pass straight through to
// the FIFO write side, and the arbiter never writes while the FIFO is full.
// Optional build macro ARB_PRIO0_EN gives requester 0 (refresh) priority at
// arbitration time without preempting an ongoing burst.
module dram_cmd_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_write_en,
  output logic [WIDTH-1:0]           fifo_write_data,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]  LAST_BEAT = CW'(MAX_BURST - 1);
  localparam logic [IDW-1:0] TOP_IDX   = IDW'(NUM_REQ - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t         state;
  logic [IDW-1:0] owner;
  logic [IDW-1:0] rr_ptr;
  logic [CW-1:0]  beat_cnt;

  logic [IDW-1:0] next_owner;
  logic [IDW-1:0] rr_next;
  logic           any_valid;
  logic           granted;
  logic           xfer;
  logic           burst_end;

  // Index base+off reduced modulo NUM_REQ (off is always below NUM_REQ)
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return sum[IDW-1:0];
  endfunction

  assign any_valid = |req_valid;
  assign granted   = (state == GRANT);

  // Choose the next owner: first valid requester at or after rr_ptr, wrapping around
  always_comb begin
    next_owner = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_idx(rr_ptr, k)]) next_owner = wrap_idx(rr_ptr, k);
    end
`ifdef ARB_PRIO0_EN
    if (req_valid[0]) next_owner = '0;
`endif
  end

  // Only the owner sees ready, and only while the FIFO has room
  always_comb begin
    req_ready = '0;
    if (granted && !fifo_full) req_ready[owner] = 1'b1;
  end

  assign xfer            = granted && !fifo_full && req_valid[owner];
  assign fifo_write_en   = xfer;
  assign fifo_write_data = req_data[int'(owner)*WIDTH +: WIDTH];
  assign burst_end       = xfer && (req_last[owner] || (beat_cnt == LAST_BEAT));

  // Rotation pointer after a burst; with priority enabled, requester 0's
  // bursts leave the rotation among the others undisturbed
  always_comb begin
    rr_next = (owner == TOP_IDX) ? '0 : owner + 1'b1;
`ifdef ARB_PRIO0_EN
    if (owner == '0) rr_next = rr_ptr;
`endif
  end

  // Arbitration FSM: IDLE picks an owner, GRANT streams its burst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            owner    <= next_owner;
            beat_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (xfer) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (burst_end) begin
              state  <= IDLE;
              rr_ptr <= rr_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign grant_id = owner;
  assign busy     = granted;

endmodule

// File: tb/tb_dram_cmd_arbiter.sv
// tb_dram_cmd_arbiter: table-driven vectors, hand-written corner sequences
// and randomized traffic checked against a transaction-level reference model.
module tb_dram_cmd_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;
  localparam int IDW       = $clog2(NUM_REQ);

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_full;
  logic                     fifo_write_en;
  logic [WIDTH-1:0]         fifo_write_data;
  logic [IDW-1:0]           grant_id;
  logic                     busy;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: who owns the port, where rotation resumes, beats sent
  bit                 mGranted;
  int                 mOwner;
  int                 mRr;
  int                 mBeats;
  logic [NUM_REQ-1:0] mAccepted;

  typedef struct {
    bit                       rstBefore;
    logic [NUM_REQ-1:0]       valid;
    logic [NUM_REQ*WIDTH-1:0] data;
    logic [NUM_REQ-1:0]       last;
    bit                       full;
    logic [NUM_REQ-1:0]       eReady;
    bit                       eWen;
    logic [WIDTH-1:0]         eData;
    logic [IDW-1:0]           eGid;
    bit                       eBusy;
  } vec_t;

  vec_t vecs[$];

  dram_cmd_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .WIDTH    (WIDTH),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_last       (req_last),
    .req_ready      (req_ready),
    .fifo_full      (fifo_full),
    .fifo_write_en  (fifo_write_en),
    .fifo_write_data(fifo_write_data),
    .grant_id       (grant_id),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(bit r, logic [3:0] v, logic [31:0] d, logic [3:0] l, bit f,
                              logic [3:0] er, bit ew, logic [7:0] ed, logic [1:0] eg, bit eb);
    vec_t t;
    t.rstBefore = r; t.valid = v; t.data = d; t.last = l; t.full = f;
    t.eReady = er; t.eWen = ew; t.eData = ed; t.eGid = eg; t.eBusy = eb;
    return t;
  endfunction

  task automatic checkVal(string name, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mGranted  = 1'b0;
    mOwner    = 0;
    mRr       = 0;
    mBeats    = 0;
    mAccepted = '0;
  endtask

  // Compare DUT outputs against what the model says this cycle must show
  task automatic checkOutput(string tag);
    logic [NUM_REQ-1:0] eReady;
    logic               eWen;
    eReady = '0;
    if (mGranted && !fifo_full) eReady[mOwner] = 1'b1;
    eWen = mGranted && !fifo_full && req_valid[mOwner];
    checkVal({tag, " busy"}, 64'(busy), 64'(mGranted));
    checkVal({tag, " grant_id"}, 64'(grant_id), 64'(mOwner));
    checkVal({tag, " req_ready"}, 64'(req_ready), 64'(eReady));
    checkVal({tag, " fifo_write_en"}, 64'(fifo_write_en), 64'(eWen));
    if (eWen) checkVal({tag, " fifo_write_data"}, 64'(fifo_write_data),
                       64'(req_data[mOwner*WIDTH +: WIDTH]));
  endtask

  // Advance the model across one clock edge using the current inputs
  task automatic modelStep();
    int pick;
    mAccepted = '0;
    if (!mGranted) begin
      if (|req_valid) begin
        pick = -1;
`ifdef ARB_PRIO0_EN
        if (req_valid[0]) pick = 0;
`endif
        for (int k = 0; k < NUM_REQ; k++)
          if (pick < 0 && req_valid[(mRr + k) % NUM_REQ]) pick = (mRr + k) % NUM_REQ;
        mOwner   = pick;
        mBeats   = 0;
        mGranted = 1'b1;
      end
    end else if (!fifo_full && req_valid[mOwner]) begin
      mAccepted[mOwner] = 1'b1;
      mBeats++;
      if (req_last[mOwner] || mBeats == MAX_BURST) begin
        mGranted = 1'b0;
`ifdef ARB_PRIO0_EN
        if (mOwner != 0) mRr = (mOwner + 1) % NUM_REQ;
`else
        mRr = (mOwner + 1) % NUM_REQ;
`endif
      end
    end
  endtask

  task automatic applyStimulus(string tag);
    #2;
    checkOutput(tag);
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    #2;
    modelReset();
    checkOutput("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int beat;
    int beat3;
    vec_t t;

    $display("[TB] start");
    rst = 1'b1;
    req_valid = '0; req_data = '0; req_last = '0; fifo_full = 1'b0;
    modelReset();

    // All four requesters single-beat: 0,1,2,3,0 with an idle cycle between
    vecs.push_back(mk(1, 4'hF, 32'hA3A2A1A0, 4'hF, 0, 4'b0000, 0, 8'h00, 2'd0, 0));
    vecs.push_back(mk(0, 4'hF, 32'hA3A2A1A0, 4'hF, 0, 4'b0001, 1, 8'hA0, 2'd0, 1));
    vecs.push_back(mk(0, 4'hF, 32'hA3A2A1A0, 4'hF, 0, 4'b0000, 0, 8'h00, 2'd0, 0));
    vecs.push_back(mk(0, 4'hF, 32'hA3A2A1A0, 4'hF, 0, 4'b0010, 1, 8'hA1, 2'd1, 1));
    vecs.push_back(mk(0, 4'hF, 32'hA3A2A1A0, 4'hF, 0, 4'b0000, 0, 8'h00, 2'd1, 0));
    vecs.push_back(mk(0, 4'hF, 32'hA3A2A1A0, 4'hF, 0, 4'b0100, 1, 8'hA2, 2'd2, 1));
    vecs.push_back(mk(0, 4'hF, 32'hA3A2A1A0, 4'hF, 0, 4'b0000, 0, 8'h00, 2'd2, 0));
    vecs.push_back(mk(0, 4'hF, 32'hA3A2A1A0, 4'hF, 0, 4'b1000, 1, 8'hA3, 2'd3, 1));
    vecs.push_back(mk(0, 4'hF, 32'hA3A2A1A0, 4'hF, 0, 4'b0000, 0, 8'h00, 2'd3, 0));
    vecs.push_back(mk(0, 4'hF, 32'hA3A2A1A0, 4'hF, 0, 4'b0001, 1, 8'hA0, 2'd0, 1));
    // Requester 1 alone, six beats: split at MAX_BURST, regranted after one idle cycle
    vecs.push_back(mk(1, 4'b0010, 32'h00001000, 4'b0000, 0, 4'b0000, 0, 8'h00, 2'd0, 0));
    vecs.push_back(mk(0, 4'b0010, 32'h00001000, 4'b0000, 0, 4'b0010, 1, 8'h10, 2'd1, 1));
    vecs.push_back(mk(0, 4'b0010, 32'h00001100, 4'b0000, 0, 4'b0010, 1, 8'h11, 2'd1, 1));
    vecs.push_back(mk(0, 4'b0010, 32'h00001200, 4'b0000, 0, 4'b0010, 1, 8'h12, 2'd1, 1));
    vecs.push_back(mk(0, 4'b0010, 32'h00001300, 4'b0000, 0, 4'b0010, 1, 8'h13, 2'd1, 1));
    vecs.push_back(mk(0, 4'b0010, 32'h00001400, 4'b0000, 0, 4'b0000, 0, 8'h00, 2'd1, 0));
    vecs.push_back(mk(0, 4'b0010, 32'h00001400, 4'b0000, 0, 4'b0010, 1, 8'h14, 2'd1, 1));
    vecs.push_back(mk(0, 4'b0010, 32'h00001500, 4'b0010, 0, 4'b0010, 1, 8'h15, 2'd1, 1));
    vecs.push_back(mk(0, 4'b0000, 32'h00000000, 4'b0000, 0, 4'b0000, 0, 8'h00, 2'd1, 0));

    foreach (vecs[n]) begin
      t = vecs[n];
      if (t.rstBefore) resetDut();
      req_valid = t.valid;
      req_data  = t.data;
      req_last  = t.last;
      fifo_full = t.full;
      #2;
      checkVal($sformatf("vec%0d busy", n), 64'(busy), 64'(t.eBusy));
      checkVal($sformatf("vec%0d grant_id", n), 64'(grant_id), 64'(t.eGid));
      checkVal($sformatf("vec%0d req_ready", n), 64'(req_ready), 64'(t.eReady));
      checkVal($sformatf("vec%0d fifo_write_en", n), 64'(fifo_write_en), 64'(t.eWen));
      if (t.eWen) checkVal($sformatf("vec%0d fifo_write_data", n), 64'(fifo_write_data), 64'(t.eData));
      @(posedge clk);
      #1;
    end

    // Requester 2 mid-burst with the FIFO full for three cycles
    resetDut();
    beat = 0;
    for (int c = 0; c < 16 && beat < 4; c++) begin
      req_valid = 4'b0100;
      req_data  = '0;
      req_data[2*WIDTH +: WIDTH] = WIDTH'(8'h20 + beat);
      req_last  = (beat == 3) ? 4'b0100 : 4'b0000;
      fifo_full = (c >= 2 && c < 5);
      if (fifo_full) begin
        #2;
        checkVal("full write_en", 64'(fifo_write_en), 64'd0);
        checkVal("full ready2", 64'(req_ready[2]), 64'd0);
        #(-0);
      end
      applyStimulus("full");
      if (mAccepted[2]) beat++;
    end
    checkVal("full beats sent", 64'(beat), 64'd4);

    // Owner 3 drops valid for two cycles while requester 0 waits
    resetDut();
    beat3 = 0;
    for (int c = 0; c < 14; c++) begin
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      if (beat3 < 4 && !(c == 2 || c == 3)) req_valid[3] = 1'b1;
      req_data[3*WIDTH +: WIDTH] = WIDTH'(8'h30 + beat3);
      if (c >= 2) begin
        req_valid[0] = !(c >= 2 && beat3 >= 4 && mOwner == 0 && !mGranted && c > 12);
        req_data[WIDTH-1:0] = 8'h55;
        req_last[0] = 1'b1;
      end
      if (c == 2 || c == 3) begin
        #2;
        checkVal("drop grant_id", 64'(grant_id), 64'd3);
        checkVal("drop busy", 64'(busy), 64'd1);
        checkVal("drop ready0", 64'(req_ready[0]), 64'd0);
      end
      applyStimulus("drop");
      if (mAccepted[3]) beat3++;
    end
    checkVal("drop beats sent", 64'(beat3), 64'd4);

    // Reset pulsed while requester 1 is two beats into a four-beat burst
    resetDut();
    beat = 0;
    for (int c = 0; c < 10 && beat < 2; c++) begin
      req_valid = 4'b0010;
      req_data  = '0;
      req_data[WIDTH +: WIDTH] = WIDTH'(8'h40 + beat);
      req_last  = '0;
      applyStimulus("prerst");
      if (mAccepted[1]) beat++;
    end
    #2;
    rst = 1'b1;
    #1;
    checkVal("midrst busy", 64'(busy), 64'd0);
    checkVal("midrst req_ready", 64'(req_ready), 64'd0);
    checkVal("midrst grant_id", 64'(grant_id), 64'd0);
    checkVal("midrst write_en", 64'(fifo_write_en), 64'd0);
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 4'hF;
    req_last  = 4'hF;
    req_data  = 32'hB3B2B1B0;
    applyStimulus("postrst");
    #2;
    checkVal("postrst grant_id", 64'(grant_id), 64'd0);
    checkVal("postrst data", 64'(fifo_write_data), 64'hB0);
    for (int c = 0; c < 6; c++) applyStimulus("postrst");

    // Randomized traffic against the reference model
    resetDut();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (mAccepted[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 9) < 4) begin
          req_valid[i] = 1'b1;
          req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
          req_last[i] = ($urandom_range(0, 3) == 0);
        end
      end
      fifo_full = ($urandom_range(0, 3) == 0);
      applyStimulus("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
